pe_bypass: RTL

PE_BYPASS -- requirements
Module: pe_bypass

---
 rtl/pe_bypass.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pe_bypass.sv
// Operand bypass unit for a 5-stage PE pipeline: picks the newest in-flight value
// for each decode-stage source, registers it into EX and raises the load-use hold.
module pe_bypass #(
  parameter int Para_Data_Width     = 32,
  parameter int Para_RF_Index_Width = 5
) (
  input  logic                           iClk,
  input  logic                           iReset_n,
  input  logic                           iID_Valid,
  input  logic [Para_RF_Index_Width-1:0] iIF_RF_Read_Addr_A,
  input  logic [Para_RF_Index_Width-1:0] iIF_RF_Read_Addr_B,
  input  logic                           iID_Read_En_A,
  input  logic                           iID_Read_En_B,
  input  logic [Para_Data_Width-1:0]     iRF_BP_Read_Data_A,
  input  logic [Para_Data_Width-1:0]     iRF_BP_Read_Data_B,
  input  logic                           iEX_Write_Enable,
  input  logic [Para_RF_Index_Width-1:0] iEX_Write_Addr,
  input  logic [Para_Data_Width-1:0]     iEX_Write_Data,
  input  logic                           iEX_Is_Load,
  input  logic                           iMEM_Write_Enable,
  input  logic [Para_RF_Index_Width-1:0] iMEM_Write_Addr,
  input  logic [Para_Data_Width-1:0]     iMEM_Write_Data,
  input  logic                           iWB_RF_Write_Enable,
  input  logic [Para_RF_Index_Width-1:0] iWB_RF_Write_Addr,
  input  logic [Para_Data_Width-1:0]     iWB_RF_Write_Data,
  input  logic                           iStall,
  input  logic                           iFlush,
  output logic [Para_Data_Width-1:0]     oBP_EX_Operand_A,
  output logic [Para_Data_Width-1:0]     oBP_EX_Operand_B,
  output logic                           oBP_EX_Valid,
  output logic [1:0]                     oBP_EX_Src_A,
  output logic [1:0]                     oBP_EX_Src_B,
  output logic                           oBP_Load_Use_Stall,
  output logic [15:0]                    oBP_Stall_Count
);

  typedef enum logic [1:0] {
    SrcRf  = 2'd0,
    SrcWb  = 2'd1,
    SrcMem = 2'd2,
    SrcEx  = 2'd3
  } srcSel_t;

  localparam int IW = Para_RF_Index_Width;
  localparam int DW = Para_Data_Width;

  // Indices 0 (zero) and 1 (PE ID) are not real pipeline results.
  function automatic logic isForwardable(input logic [IW-1:0] idx);
    return idx > IW'(1);
  endfunction

  // A load in EX has no data yet, so it never wins the priority chain.
  function automatic srcSel_t pickSource(
    input logic [IW-1:0] idx,
    input logic          exFwdEn,
    input logic [IW-1:0] exAddr,
    input logic          memEn,
    input logic [IW-1:0] memAddr,
    input logic          wbEn,
    input logic [IW-1:0] wbAddr
  );
    if (!isForwardable(idx))             return SrcRf;
    else if (exFwdEn && exAddr == idx)   return SrcEx;
    else if (memEn && memAddr == idx)    return SrcMem;
    else if (wbEn && wbAddr == idx)      return SrcWb;
    else                                 return SrcRf;
  endfunction

  function automatic logic [DW-1:0] muxSource(
    input srcSel_t       sel,
    input logic [DW-1:0] rfData,
    input logic [DW-1:0] wbData,
    input logic [DW-1:0] memData,
    input logic [DW-1:0] exData
  );
    case (sel)
      SrcEx:   return exData;
      SrcMem:  return memData;
      SrcWb:   return wbData;
      default: return rfData;
    endcase
  endfunction

  logic          exFwdEn;
  srcSel_t       selSrcA, selSrcB;
  logic [DW-1:0] selDataA, selDataB;
  logic          loadHitA, loadHitB;
  logic          loadUse;

  assign exFwdEn = iEX_Write_Enable && !iEX_Is_Load;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    selSrcA  = SrcRf;
    selSrcB  = SrcRf;
    selDataA = iRF_BP_Read_Data_A;
    selDataB = iRF_BP_Read_Data_B;

    selSrcA = pickSource(iIF_RF_Read_Addr_A, exFwdEn, iEX_Write_Addr,
                         iMEM_Write_Enable, iMEM_Write_Addr,
                         iWB_RF_Write_Enable, iWB_RF_Write_Addr);
    selSrcB = pickSource(iIF_RF_Read_Addr_B, exFwdEn, iEX_Write_Addr,
                         iMEM_Write_Enable, iMEM_Write_Addr,
                         iWB_RF_Write_Enable, iWB_RF_Write_Addr);

    selDataA = muxSource(selSrcA, iRF_BP_Read_Data_A, iWB_RF_Write_Data,
                         iMEM_Write_Data, iEX_Write_Data);
    selDataB = muxSource(selSrcB, iRF_BP_Read_Data_B, iWB_RF_Write_Data,
                         iMEM_Write_Data, iEX_Write_Data);
  end

  assign loadHitA = iID_Read_En_A && isForwardable(iIF_RF_Read_Addr_A)
                    && (iIF_RF_Read_Addr_A == iEX_Write_Addr);
  assign loadHitB = iID_Read_En_B && isForwardable(iIF_RF_Read_Addr_B)
                    && (iIF_RF_Read_Addr_B == iEX_Write_Addr);
  assign loadUse  = iID_Valid && iEX_Write_Enable && iEX_Is_Load && (loadHitA || loadHitB);

  assign oBP_Load_Use_Stall = loadUse;

  // NOTE: sequential state uses non-blocking assignments so all registers sample
  // the same pre-edge values; reset is asynchronous and leaves nothing pending.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      oBP_EX_Operand_A <= '0;
      oBP_EX_Operand_B <= '0;
      oBP_EX_Src_A     <= SrcRf;
      oBP_EX_Src_B     <= SrcRf;
      oBP_EX_Valid     <= 1'b0;
    end else if (iFlush) begin
      oBP_EX_Valid <= 1'b0;
    end else if (iStall) begin
      oBP_EX_Valid <= oBP_EX_Valid;
    end else if (loadUse) begin
      oBP_EX_Operand_A <= '0;
      oBP_EX_Operand_B <= '0;
      oBP_EX_Src_A     <= SrcRf;
      oBP_EX_Src_B     <= SrcRf;
      oBP_EX_Valid     <= 1'b0;
    end else begin
      oBP_EX_Operand_A <= selDataA;
      oBP_EX_Operand_B <= selDataB;
      oBP_EX_Src_A     <= selSrcA;
      oBP_EX_Src_B     <= selSrcB;
      oBP_EX_Valid     <= iID_Valid;
    end
  end

  // Counts only bubbles that are actually inserted, saturating at all-ones.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      oBP_Stall_Count <= 16'd0;
    end else if (loadUse && !iStall && !iFlush && oBP_Stall_Count != 16'hFFFF) begin
      oBP_Stall_Count <= oBP_Stall_Count + 16'd1;
    end
  end

endmodule
